// File: rtl/dcp_tx_print.sv
// dcp_tx_print: output formatter of the debug control panel.
// Executes one print request from the DCP command FSM and returns
// completion via a four-phase req_tx/ack_tx handshake.
// A request is a raw character or a 32-bit word printed as ASCII hex.
// Optional build macro: DCP_TX_CRLF_EN (raw 0x0A is expanded to 0x0D 0x0A).
// Parameters:
//   HEX_DIGITS - low-order nibbles printed for a hex request (1..8), MSB first
//   UPPER_HEX  - 1: A-F upper case, 0: a-f lower case
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   req_tx, type_tx  - request level; 0 raw dout_tx[7:0], 1 hex word
//   dout_tx          - data to print, sampled only at capture
//   ack_tx           - request complete, held until req_tx is low
//   d_tx/vld_tx/rdy_tx - byte stream to the UART transmitter
//   busy             - high outside IDLE
module dcp_tx_print #(
  parameter int unsigned HEX_DIGITS = 8,
  parameter bit          UPPER_HEX  = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap_type, cap_type_nxt;
  logic [31:0] cap_data, cap_data_nxt;

  logic [2:0]  nib_sel;
  logic [3:0]  nib;
  logic [7:0]  hex_chr;
  logic [7:0]  raw_chr;
  logic [3:0]  raw_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_type <= 1'b0;
      cap_data <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cap_type <= cap_type_nxt;
      cap_data <= cap_data_nxt;
    end
  end

  // cnt counts bytes still to send, so the current hex digit k maps to
  // nibble HEX_DIGITS-1-k = cnt-1 without a separate digit index.
  always_comb begin
    nib_sel = 3'(cnt - 4'd1);
    nib     = cap_data[{nib_sel, 2'b00} +: 4];
    if (nib < 4'd10)
      hex_chr = 8'h30 + {4'h0, nib};
    else
      hex_chr = (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
  end

`ifdef DCP_TX_CRLF_EN
  always_comb begin
    raw_chr = cap_data[7:0];
    if (cap_data[7:0] == 8'h0A && cnt == 4'd2)
      raw_chr = 8'h0D;
    raw_cnt = (dout_tx[7:0] == 8'h0A) ? 4'd2 : 4'd1;
  end
`else
  always_comb begin
    raw_chr = cap_data[7:0];
    raw_cnt = 4'd1;
  end
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cap_type_nxt = cap_type;
    cap_data_nxt = cap_data;
    vld_tx       = 1'b0;
    ack_tx       = 1'b0;
    busy         = 1'b1;
    d_tx         = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req_tx) begin
          cap_type_nxt = type_tx;
          cap_data_nxt = dout_tx;
          cnt_nxt      = type_tx ? 4'(HEX_DIGITS) : raw_cnt;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        vld_tx = 1'b1;
        d_tx   = cap_type ? hex_chr : raw_chr;
        if (rdy_tx) begin
          if (cnt == 4'd1) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      DONE: begin
        ack_tx = 1'b1;
        if (!req_tx)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcp_tx_print.sv
// tb_dcp_tx_print: directed self-checking bench for dcp_tx_print
// (HEX_DIGITS=8, UPPER_HEX=1). Honours DCP_TX_CRLF_EN for the CRLF case.
module tb_dcp_tx_print;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_tx = 1'b0;
  logic        type_tx = 1'b0;
  logic [31:0] dout_tx = '0;
  logic        ack_tx;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx = 1'b1;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];

  dcp_tx_print #(.HEX_DIGITS(8), .UPPER_HEX(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req_tx(req_tx), .type_tx(type_tx),
    .dout_tx(dout_tx), .ack_tx(ack_tx), .d_tx(d_tx), .vld_tx(vld_tx),
    .rdy_tx(rdy_tx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rstn && vld_tx && rdy_tx) q.push_back(d_tx);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [63:0] exp);
    check({tag, "_count"}, q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < q.size()) check({tag, "_byte"}, {24'h0, q[i]}, {24'h0, exp[8*(n-1-i) +: 8]});
  endtask

  // Full four-phase request; inputs other than req_tx are scrambled after
  // capture to show they are ignored during SEND.
  task automatic send(input logic t, input logic [31:0] d, input int hold,
                      output int vcyc, output int lat);
    int n0;
    q.delete();
    req_tx = 1'b1; type_tx = t; dout_tx = d;
    vcyc = 0; lat = 0;
    @(negedge clk);
    type_tx = ~t; dout_tx = ~d;
    while (ack_tx !== 1'b1 && lat < 200) begin
      if (vld_tx) vcyc++;
      @(negedge clk);
      lat++;
    end
    check("ack_rise", {31'h0, ack_tx}, 1);
    n0 = q.size();
    repeat (hold) begin
      @(negedge clk);
      check("ack_hold", {31'h0, ack_tx}, 1);
      check("no_extra_bytes", q.size(), n0);
    end
    req_tx = 1'b0;
    @(negedge clk);
    check("ack_fall", {31'h0, ack_tx}, 0);
    check("busy_idle", {31'h0, busy}, 0);
  endtask

  initial begin
    int vc, lt, w;
    repeat (2) @(negedge clk);
    check("rst_vld", {31'h0, vld_tx}, 0);
    check("rst_ack", {31'h0, ack_tx}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_d", {24'h0, d_tx}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // raw character
    send(1'b0, 32'h0000_0041, 0, vc, lt);
    check_bytes("raw41", 1, 64'h41);
    check("raw_vld_cycles", vc, 1);
    check("raw_ack_latency", lt, 1);

    // hex word, with req_tx held 5 cycles past ack
    send(1'b1, 32'h1234_ABCD, 5, vc, lt);
    check_bytes("hex1234ABCD", 8, 64'h3132_3334_4142_4344);
    check("hex_vld_cycles", vc, 8);
    check("hex_ack_latency", lt, 8);

    // backpressure at digit 4
    q.delete();
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'h0000_000F;
    repeat (5) @(negedge clk);
    rdy_tx = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_d", {24'h0, d_tx}, 32'h30);
      check("bp_vld", {31'h0, vld_tx}, 1);
    end
    rdy_tx = 1'b1;
    w = 0;
    while (ack_tx !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    check("bp_ack", {31'h0, ack_tx}, 1);
    req_tx = 1'b0;
    @(negedge clk);
    check_bytes("bp_stream", 8, 64'h3030_3030_3030_3046);

    // req_tx dropped right after capture: one-cycle ack
    q.delete();
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'h0000_0009;
    @(negedge clk);
    req_tx = 1'b0;
    w = 0;
    while (ack_tx !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    check("early_ack", {31'h0, ack_tx}, 1);
    @(negedge clk);
    check("early_ack_one", {31'h0, ack_tx}, 0);
    check("early_busy", {31'h0, busy}, 0);
    check_bytes("early_stream", 8, 64'h3030_3030_3030_3039);

    // reset during digit 3 of 0xDEADBEEF
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    check("pre_rst_digit3", {24'h0, d_tx}, 32'h44);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_vld", {31'h0, vld_tx}, 0);
    check("mid_rst_ack", {31'h0, ack_tx}, 0);
    check("mid_rst_busy", {31'h0, busy}, 0);
    req_tx = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(1'b1, 32'hDEAD_BEEF, 0, vc, lt);
    check_bytes("after_rst", 8, 64'h4445_4144_4245_4546);

    // newline handling
    send(1'b0, 32'h0000_000A, 0, vc, lt);
`ifdef DCP_TX_CRLF_EN
    check_bytes("crlf", 2, 64'h0D0A);
`else
    check_bytes("lf", 1, 64'h0A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
